echo_delay: RTL and testbench

ECHO_DELAY -- requirements
Module: echo_delay

---
 rtl/echo_delay.sv | 125 ++++++++++++
 tb/tb_echo_delay.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/echo_delay.sv
// Single-tap delay / feedback echo on a circular sample memory, one sample per 5-cycle frame.
// Define ECHO_DELAY_SAT_EN to clamp the dry+wet sum; otherwise the sum is halved.
module echo_delay #(
    parameter int WIDTH     = 16,
    parameter int MAX_DEPTH = 32768,
    parameter int LEN_W     = $clog2(MAX_DEPTH)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    sample_valid_in,
    input  logic signed [WIDTH-1:0] data_dry,
    input  logic        [1:0]       mode,
    input  logic        [LEN_W-1:0] delay_len,
    input  logic        [1:0]       fb_shift,
    output logic signed [WIDTH-1:0] data_wet,
    output logic                    wet_valid_out,
    output logic                    overrun
);
    localparam int PTR_W = $clog2(MAX_DEPTH);
    localparam int CNT_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, MIX, WRITE} state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        wr_ptr_q, len_q, len_d, rd_addr_q, rd_addr_d;
    logic [PTR_W:0]          rd_diff;
    logic [CNT_W-1:0]        fill_q;
    logic [1:0]              mode_q, fb_q;
    logic signed [WIDTH-1:0] dry_q, rd_data_q, res_q, res_d, data_wet_q;
    logic signed [WIDTH-1:0] delayed, shifted, wr_data;
    logic signed [WIDTH:0]   sum;
    logic                    wet_valid_q, overrun_q;
    logic                    wet_sel;

    logic signed [WIDTH-1:0] mem [MAX_DEPTH];

    always_comb begin
        len_d = PTR_W'(delay_len);
        if (delay_len == '0)
            len_d = PTR_W'(1);
        else if (32'(delay_len) > 32'(MAX_DEPTH - 1))
            len_d = PTR_W'(MAX_DEPTH - 1);
    end

    // Extra top bit of the difference flags a wrap below zero.
    always_comb begin
        rd_diff   = {1'b0, wr_ptr_q} - {1'b0, len_q};
        rd_addr_d = rd_diff[PTR_W] ? PTR_W'(rd_diff + (PTR_W + 1)'(MAX_DEPTH))
                                   : rd_diff[PTR_W-1:0];
    end

    always_comb begin
        delayed = (fill_q < CNT_W'(len_q)) ? '0 : rd_data_q;
        shifted = delayed >>> ({1'b0, fb_q} + 3'd1);
        sum     = {dry_q[WIDTH-1], dry_q} + {shifted[WIDTH-1], shifted};
`ifdef ECHO_DELAY_SAT_EN
        if (sum[WIDTH] != sum[WIDTH-1])
            res_d = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res_d = sum[WIDTH-1:0];
`else
        res_d = sum[WIDTH:1];
`endif
    end

`ifndef ECHO_DELAY_SAT_EN
    logic unused_lsb;
    assign unused_lsb = sum[0];
`endif

    assign wet_sel = (mode_q == 2'b01) || (mode_q == 2'b10);
    assign wr_data = (mode_q == 2'b10) ? res_q : dry_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            data_wet_q  <= '0;
            wet_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wet_valid_q <= 1'b0;
            overrun_q   <= sample_valid_in && (state_q != IDLE);
            case (state_q)
                IDLE: if (sample_valid_in) begin
                    dry_q   <= data_dry;
                    mode_q  <= mode;
                    fb_q    <= fb_shift;
                    len_q   <= len_d;
                    state_q <= READ;
                end
                READ: begin
                    rd_addr_q <= rd_addr_d;
                    state_q   <= WAIT;
                end
                WAIT: state_q <= MIX;
                MIX: begin
                    res_q   <= res_d;
                    state_q <= WRITE;
                end
                WRITE: begin
                    data_wet_q  <= wet_sel ? res_q : dry_q;
                    wet_valid_q <= 1'b1;
                    wr_ptr_q    <= (wr_ptr_q == PTR_W'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                    if (fill_q != CNT_W'(MAX_DEPTH))
                        fill_q <= fill_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-stage read: address register (READ) then output register (WAIT).
    always_ff @(posedge clk_in) begin
        if (!rst_in && state_q == WRITE)
            mem[wr_ptr_q] <= wr_data;
        rd_data_q <= mem[rd_addr_q];
    end

    assign data_wet      = data_wet_q;
    assign wet_valid_out = wet_valid_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_echo_delay.sv
// Directed-vector bench for echo_delay: driver queues expected samples, monitor checks outputs.
module tb_echo_delay;
    localparam int W = 16, D = 16, LW = 5;
`ifdef ECHO_DELAY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clk_in = 1'b0, rst_in = 1'b1, sample_valid_in = 1'b0;
    logic signed [W-1:0]  data_dry = '0;
    logic        [1:0]    mode = '0, fb_shift = '0;
    logic        [LW-1:0] delay_len = '0;
    logic signed [W-1:0]  data_wet;
    logic                 wet_valid_out, overrun;

    echo_delay #(.WIDTH(W), .MAX_DEPTH(D), .LEN_W(LW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_valid_in(sample_valid_in),
        .data_dry(data_dry), .mode(mode), .delay_len(delay_len), .fb_shift(fb_shift),
        .data_wet(data_wet), .wet_valid_out(wet_valid_out), .overrun(overrun));

    always #5 clk_in = ~clk_in;

    typedef struct { logic signed [W-1:0] data; int cyc; } exp_t;
    exp_t q[$];
    exp_t e;
    int   checks = 0, failures = 0, cyc = 0;
    bit   started = 0, done = 0, fin = 0, rst_seen = 1, ovr_exp = 0;
    logic signed [W-1:0] last_wet;

    int t1s[8] = '{1000, 0, 0, 0, 500, 0, 0, 0};
    int t1n[8] = '{500, 0, 0, 0, 250, 0, 0, 0};
    int t2s[8] = '{8000, 0, 4000, 0, 2000, 0, 1000, 0};
    int t2n[8] = '{4000, 0, 1000, 0, 250, 0, 62, 0};

    always @(posedge clk_in) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_in;
    end

    always @(negedge clk_in) begin
        if (started) begin
            checks++;
            if (overrun !== ovr_exp) begin
                failures++;
                $display("FAIL overrun cyc=%0d got=%0b exp=%0b", cyc, overrun, ovr_exp);
            end
            if (rst_seen) begin
                checks++;
                if (data_wet !== '0 || wet_valid_out !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state wet=%0d valid=%0b exp 0/0", data_wet, wet_valid_out);
                end
                last_wet = data_wet;
            end else if (wet_valid_out) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_wet cyc=%0d got=%0d", cyc, data_wet);
                end else begin
                    e = q.pop_front();
                    if (data_wet !== e.data || cyc != e.cyc) begin
                        failures++;
                        $display("FAIL wet_sample got=%0d@%0d exp=%0d@%0d", data_wet, cyc, e.data, e.cyc);
                    end
                end
                last_wet = data_wet;
            end else begin
                checks++;
                if (data_wet !== last_wet) begin
                    failures++;
                    $display("FAIL wet_hold cyc=%0d got=%0d exp=%0d", cyc, data_wet, last_wet);
                end
            end
        end
        if (done && !fin) begin
            checks++;
            if (q.size() != 0) begin
                failures++;
                $display("FAIL missing_wet outstanding=%0d exp=0", q.size());
            end
            fin = 1;
        end
    end

    function automatic logic signed [W-1:0] pk(input int s, input int n);
        return SAT ? W'(s) : W'(n);
    endfunction

    task automatic send(input int d, input logic [1:0] m, input int dl,
                        input logic [1:0] fb, input logic signed [W-1:0] ex);
        @(posedge clk_in); #1;
        data_dry = W'(d); mode = m; delay_len = LW'(dl); fb_shift = fb;
        sample_valid_in = 1'b1;
        q.push_back('{ex, cyc + 5});
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        data_dry = ~data_dry; mode = ~mode; delay_len = ~delay_len; fb_shift = ~fb_shift;
        repeat (3) @(posedge clk_in);
    endtask

    task automatic do_reset();
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        started = 1;

        // delay mode, L=4 impulse
        for (int i = 0; i < 8; i++) send(i == 0 ? 1000 : 0, 2'b01, 4, 2'b00, pk(t1s[i], t1n[i]));
        // echo mode, L=2 impulse
        do_reset();
        for (int i = 0; i < 8; i++) send(i == 0 ? 8000 : 0, 2'b10, 2, 2'b00, pk(t2s[i], t2n[i]));
        // overflow in both directions
        do_reset();
        send(30000, 2'b01, 1, 2'b00, pk(30000, 15000));
        send(30000, 2'b01, 1, 2'b00, pk(32767, 22500));
        send(30000, 2'b01, 1, 2'b00, pk(32767, 22500));
        do_reset();
        send(-30000, 2'b01, 1, 2'b00, pk(-30000, -15000));
        send(-30000, 2'b01, 1, 2'b00, pk(-32768, -22500));
        // delay_len=0 acts as 1; larger fb_shift values
        do_reset();
        send(100, 2'b01, 0, 2'b01, pk(100, 50));
        send(200, 2'b01, 0, 2'b01, pk(225, 112));
        send(300, 2'b01, 0, 2'b01, pk(350, 175));
        do_reset();
        send(-1600, 2'b01, 0, 2'b11, pk(-1600, -800));
        send(0, 2'b01, 0, 2'b11, pk(-100, -50));
        // delay_len=20 clamps to 15; pointer wraps 15->0
        do_reset();
        for (int i = 0; i < 20; i++)
            send(i == 0 ? 1000 : (i == 1 ? 2000 : 0), 2'b01, 20, 2'b00,
                 i == 0 ? pk(1000, 500) : i == 1 ? pk(2000, 1000) :
                 i == 15 ? pk(500, 250) : i == 16 ? pk(1000, 500) : pk(0, 0));
        // strobe two cycles into a frame is dropped
        do_reset();
        @(posedge clk_in); #1;
        data_dry = 16'sd777; mode = 2'b00; delay_len = 5'd3; sample_valid_in = 1'b1;
        q.push_back('{16'sd777, cyc + 5});
        @(posedge clk_in); #1 sample_valid_in = 1'b0;
        @(posedge clk_in); #1 sample_valid_in = 1'b1; data_dry = 16'sd555;
        @(posedge clk_in); #1 sample_valid_in = 1'b0; ovr_exp = 1;
        @(posedge clk_in); #1 ovr_exp = 0;
        repeat (3) @(posedge clk_in);
        // fill memory with stale data in bypass modes, abort a frame in WAIT
        do_reset();
        for (int i = 0; i < 16; i++) send(1234, (i % 2 == 0) ? 2'b00 : 2'b11, 1, 2'b00, 16'sd1234);
        @(posedge clk_in); #1;
        data_dry = 16'sd5000; mode = 2'b01; delay_len = 5'd1; sample_valid_in = 1'b1;
        @(posedge clk_in); #1 sample_valid_in = 1'b0;
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        repeat (8) @(posedge clk_in);
        send(100, 2'b01, 1, 2'b00, pk(100, 50));
        // strobe coincident with reset is ignored
        @(posedge clk_in); #1 rst_in = 1'b1; sample_valid_in = 1'b1; data_dry = 16'sd999;
        @(posedge clk_in); #1 rst_in = 1'b0; sample_valid_in = 1'b0;
        repeat (8) @(posedge clk_in);
        send(-7, 2'b00, 1, 2'b00, -16'sd7);

        repeat (4) @(posedge clk_in);
        done = 1;
        @(negedge clk_in); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
